sdp_share_arb: RTL and testbench
================================

Name: sdp_share_arb

Overview:
- Shares one LAT-deep pipelined 8-bit datapath (ctl_1/ctl_2 plus a/b/c operands in, one result out) between two requesters.
- Round-robin arbitration issues one operation per cycle.
- A tag pipeline tracks in-flight operations so each result is steered back to the requester that issued it.
- A small FSM handles post-reset datapath initialisation and requester-initiated flush (drain, then datapath reset).

Parameters:
- W, 8, operand/result width
- LAT, 3, datapath latency in cycles from operand presentation to dp_out (>=1)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_ctl  input  2  {ctl_2, ctl_1} for requester 0
- req0_a, req0_b, req0_c  input  W each  requester 0 operands
- req1_valid, req1_ready, req1_ctl, req1_a, req1_b, req1_c  same, requester 1
- rsp0_valid  output  1  one-cycle result pulse for requester 0
- rsp0_data  output  W  result for requester 0
- rsp1_valid, rsp1_data  same, requester 1
- dp_reset  output  1  reset to shared datapath
- dp_ctl_1, dp_ctl_2  output  1 each  datapath controls
- dp_a, dp_b, dp_c  output  W each  datapath operands
- dp_out  input  W  datapath result
- flush_req  input  1  request drain plus datapath reset (level, sampled)
- flush_done  output  1  one-cycle pulse when flush completes
- busy  output  1  in-flight count nonzero or state != RUN

Behaviour:
- FSM states: INIT, RUN, DRAIN, CLEAR.
- Reset -> INIT. All rsp*_valid=0, rsp*_data=0, flush_done=0, tag pipe cleared, inflight=0, rr pointer=0 (req0 favoured).
- INIT: dp_reset=1 for exactly one cycle, then RUN.
- RUN: grants allowed.
  - flush_req=1 sampled in RUN -> DRAIN next cycle.
  - No grant in the cycle flush_req is sampled high.
- DRAIN: no grants. When inflight==0 -> CLEAR.
- CLEAR: dp_reset=1 for one cycle, flush_done=1 that same cycle, then RUN.
  - flush_req still high in RUN re-enters DRAIN; requester holds it for one cycle only.
- dp_reset = reset OR state in {INIT, CLEAR}.
- Arbitration (RUN only):
  - One valid requester -> it is granted.
  - Both valid -> grant goes to rr pointer.
  - After any grant, pointer = other requester.
- Handshake:
  - reqN_ready is combinational and equals the grant; ready is 0 outside RUN.
  - Transfer occurs when valid and ready are both high.
  - Requesters hold payload stable while valid and not ready.
- dp_* combinational from the granted requester's payload; all zero when there is no grant.
- Tag pipe: LAT stages of {vld, id}, shifted every cycle. Stage 0 loaded with {grant_any, grant_id}.
  - Stage LAT-1 aligns with dp_out.
- Responses (registered): rspN_valid<=tag_out.vld & tag_out.id==N; rspN_data<=dp_out when valid, else holds.
  - Latency is LAT+1 cycles from handshake; for LAT=3, handshake in cycle 0 -> rsp in cycle 4.
- inflight: counter 0..LAT+1.
  - +1 on grant; -1 when a response is registered; simultaneous +1/-1 leaves it unchanged.
  - Never exceeds LAT+1; one issue per cycle bounds it.
- Reset mid-operation clears tags and drops pending results, with no rsp pulses afterwards.
- Garbage dp_out in unissued slots is never forwarded.

Optional Feature:
- SDP_ARB_STATS_EN defined:
  - Adds outputs gnt0_cnt, gnt1_cnt (16 bits each), counting grants per requester.
  - Counters saturate at 16'hFFFF and clear on reset only (not on flush).
  - Adds stall_cnt (16 bits, saturating): cycles where some valid=1 but no grant.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package sdp_arb_pkg:
  - state enum (INIT, RUN, DRAIN, CLEAR)
  - tag struct {vld, id}
  - default W/LAT constants
- Sub-module sdp_tag_pipe: LAT-stage shift register of tags with synchronous clear.
- Arbiter, FSM and response registers stay in the top.

Test Plan:
- Reset, then idle: dp_reset high in reset cycle and first INIT cycle, then low; all rsp*_valid stay 0 for 10 cycles; busy=0 after INIT.
- req0 alone, ctl=2'b01, a=8'h12, b=8'h34, c=8'h56, one cycle:
  - req0_ready=1, dp_a=8'h12 in that cycle.
  - rsp0_valid pulses exactly 4 cycles later with rsp0_data = dp_out from cycle 3.
  - rsp1_valid never asserts.
- Both valid for 6 cycles from reset pointer: grants alternate 0,1,0,1,0,1; rsp pulses alternate with the same order, offset 4 cycles.
- Flush with 3 ops in flight:
  - No grants from the flush cycle onward.
  - All 3 responses delivered, then one cycle of dp_reset with flush_done.
  - Grants resume the following cycle.
- Reset asserted 2 cycles after a grant: no rsp pulse ever appears for that op; inflight=0; INIT sequence repeats.
- Saturation (SDP_ARB_STATS_EN): force 70000 req0 grants → gnt0_cnt=16'hFFFF; gnt1_cnt=0.

Source files
------------

// File: rtl/sdp_arb_pkg.sv
// sdp_arb_pkg -- shared types and defaults for the shared-datapath arbiter.
//   state_e   : controller states (INIT, RUN, DRAIN, CLEAR)
//   tag_t     : in-flight operation tag {vld, id}
//   W_DEF     : default operand/result width
//   LAT_DEF   : default datapath latency
//   sat_inc16 : 16-bit saturating increment, used by the optional statistics
package sdp_arb_pkg;

    localparam int W_DEF   = 8;
    localparam int LAT_DEF = 3;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_CLEAR = 2'd3
    } state_e;

    typedef struct packed {
        logic vld;
        logic id;
    } tag_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

endpackage

// File: rtl/sdp_tag_pipe.sv
// sdp_tag_pipe -- LAT-stage shift register of operation tags. The last stage
// lines up with the shared datapath output so the result can be steered.
// Ports:
//   clk   : clock
//   clr   : synchronous clear of every stage
//   tag_i : tag entering stage 0 this cycle
//   tag_o : tag in stage LAT-1 (belongs to the current dp_out)
module sdp_tag_pipe
    import sdp_arb_pkg::*;
#(
    parameter int LAT = LAT_DEF
) (
    input  logic clk,
    input  logic clr,
    input  tag_t tag_i,
    output tag_t tag_o
);

    tag_t stage_q [LAT];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < LAT; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[LAT-1];

endmodule

// File: rtl/sdp_share_arb.sv
// sdp_share_arb -- shares one LAT-deep pipelined datapath between two
// requesters with round-robin issue, tag-based response steering and a small
// controller for datapath initialisation and requester-initiated flush.
//
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   reqN_valid/ready               : issue handshake for requester N (ready is combinational)
//   reqN_ctl, reqN_a/b/c           : {ctl_2, ctl_1} and operands for requester N
//   rspN_valid, rspN_data          : registered one-cycle result pulse and held result
//   dp_reset                       : reset to the shared datapath
//   dp_ctl_1/2, dp_a/b/c           : datapath controls/operands (zero when nothing is issued)
//   dp_out                         : datapath result, LAT cycles after the operands
//   flush_req, flush_done          : drain-and-reset request (sampled level), completion pulse
//   busy                           : operations in flight or controller not in RUN
// Optional (macro SDP_ARB_STATS_EN):
//   gnt0_cnt, gnt1_cnt, stall_cnt  : saturating 16-bit grant and stall counters
//
// Controller states:
//   state    | meaning
//   ST_INIT  | one cycle of datapath reset after system reset
//   ST_RUN   | issuing operations, round-robin between requesters
//   ST_DRAIN | no issue; waiting for all in-flight results to come back
//   ST_CLEAR | one cycle of datapath reset, flush_done pulses
module sdp_share_arb
    import sdp_arb_pkg::*;
#(
    parameter int W   = W_DEF,
    parameter int LAT = LAT_DEF
) (
    input  logic         clk,
    input  logic         reset,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [1:0]   req0_ctl,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [W-1:0] req0_c,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [1:0]   req1_ctl,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [W-1:0] req1_c,

    output logic         rsp0_valid,
    output logic [W-1:0] rsp0_data,
    output logic         rsp1_valid,
    output logic [W-1:0] rsp1_data,

    output logic         dp_reset,
    output logic         dp_ctl_1,
    output logic         dp_ctl_2,
    output logic [W-1:0] dp_a,
    output logic [W-1:0] dp_b,
    output logic [W-1:0] dp_c,
    input  logic [W-1:0] dp_out,

    input  logic         flush_req,
    output logic         flush_done,
    output logic         busy
`ifdef SDP_ARB_STATS_EN
    ,
    output logic [15:0]  gnt0_cnt,
    output logic [15:0]  gnt1_cnt,
    output logic [15:0]  stall_cnt
`endif
);

    // Wide enough to hold LAT+1.
    localparam int IFW = $clog2(LAT + 2);

    state_e         state_q;
    logic           dp_rst_q;
    logic           flush_done_q;
    logic           rr_q, rr_d;
    logic [IFW-1:0] inflight_q, inflight_d;
    logic           rsp0_valid_q, rsp1_valid_q;
    logic [W-1:0]   rsp0_data_q, rsp1_data_q;

    logic           grant_en, gnt0, gnt1, grant_any;
    tag_t           tag_in, tag_out;

    // ---------------------------------------------------------------
    // Arbitration: rr_q names the requester favoured on a tie.
    // No issue in the cycle a flush request is sampled.
    // ---------------------------------------------------------------
    assign grant_en  = (state_q == ST_RUN) && !flush_req;
    assign gnt0      = grant_en && req0_valid && (!req1_valid || !rr_q);
    assign gnt1      = grant_en && req1_valid && (!req0_valid ||  rr_q);
    assign grant_any = gnt0 || gnt1;

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_comb begin
        rr_d = rr_q;
        if (gnt0) begin
            rr_d = 1'b1;
        end else if (gnt1) begin
            rr_d = 1'b0;
        end
    end

    always_comb begin
        dp_ctl_1 = 1'b0;
        dp_ctl_2 = 1'b0;
        dp_a     = '0;
        dp_b     = '0;
        dp_c     = '0;
        if (gnt0) begin
            {dp_ctl_2, dp_ctl_1} = req0_ctl;
            dp_a = req0_a;
            dp_b = req0_b;
            dp_c = req0_c;
        end else if (gnt1) begin
            {dp_ctl_2, dp_ctl_1} = req1_ctl;
            dp_a = req1_a;
            dp_b = req1_b;
            dp_c = req1_c;
        end
    end

    // ---------------------------------------------------------------
    // Tag pipeline: its last stage describes the slot currently on dp_out.
    // ---------------------------------------------------------------
    assign tag_in = '{vld: grant_any, id: gnt1};

    sdp_tag_pipe #(
        .LAT (LAT)
    ) u_tag_pipe (
        .clk   (clk),
        .clr   (reset),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    // In-flight count: an op leaves the count on the edge that registers its result.
    always_comb begin
        inflight_d = inflight_q;
        if (grant_any && !tag_out.vld) begin
            inflight_d = inflight_q + IFW'(1);
        end else if (!grant_any && tag_out.vld) begin
            inflight_d = inflight_q - IFW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q         <= 1'b0;
            inflight_q   <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_data_q  <= '0;
            rsp1_data_q  <= '0;
        end else begin
            rr_q         <= rr_d;
            inflight_q   <= inflight_d;
            rsp0_valid_q <= tag_out.vld && !tag_out.id;
            rsp1_valid_q <= tag_out.vld &&  tag_out.id;
            // Unissued slots carry garbage on dp_out; only tagged slots are captured.
            if (tag_out.vld && !tag_out.id) begin
                rsp0_data_q <= dp_out;
            end
            if (tag_out.vld && tag_out.id) begin
                rsp1_data_q <= dp_out;
            end
        end
    end

    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_data  = rsp0_data_q;
    assign rsp1_data  = rsp1_data_q;

    // ---------------------------------------------------------------
    // Controller. dp_rst_q / flush_done_q are loaded with the decode of
    // the next state so both are plain register outputs.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_INIT;
            dp_rst_q     <= 1'b1;
            flush_done_q <= 1'b0;
        end else begin
            dp_rst_q     <= 1'b0;
            flush_done_q <= 1'b0;
            case (state_q)
                ST_INIT: begin
                    state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (flush_req) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (inflight_q == '0) begin
                        state_q      <= ST_CLEAR;
                        dp_rst_q     <= 1'b1;
                        flush_done_q <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    state_q <= ST_RUN;
                end
                default: begin
                    state_q  <= ST_INIT;
                    dp_rst_q <= 1'b1;
                end
            endcase
        end
    end

    assign dp_reset   = reset || dp_rst_q;
    assign flush_done = flush_done_q;
    assign busy       = (inflight_q != '0) || (state_q != ST_RUN);

`ifdef SDP_ARB_STATS_EN
    logic [15:0] gnt0_cnt_q, gnt1_cnt_q, stall_cnt_q;

    // Cleared by system reset only; a flush leaves the statistics intact.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt0_cnt_q  <= '0;
            gnt1_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            gnt0_cnt_q  <= sat_inc16(gnt0_cnt_q, gnt0);
            gnt1_cnt_q  <= sat_inc16(gnt1_cnt_q, gnt1);
            stall_cnt_q <= sat_inc16(stall_cnt_q, (req0_valid || req1_valid) && !grant_any);
        end
    end

    assign gnt0_cnt  = gnt0_cnt_q;
    assign gnt1_cnt  = gnt1_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sdp_share_arb.sv
module tb_sdp_share_arb;

    localparam int W   = 8;
    localparam int LAT = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0]   req0_ctl, req1_ctl;
    logic [W-1:0] req0_a, req0_b, req0_c, req1_a, req1_b, req1_c;
    logic         rsp0_valid, rsp1_valid;
    logic [W-1:0] rsp0_data, rsp1_data;
    logic         dp_reset, dp_ctl_1, dp_ctl_2;
    logic [W-1:0] dp_a, dp_b, dp_c, dp_out;
    logic         flush_req, flush_done, busy;
`ifdef SDP_ARB_STATS_EN
    logic [15:0]  gnt0_cnt, gnt1_cnt, stall_cnt;
`endif

    sdp_share_arb #(.W(W), .LAT(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_ctl   (req0_ctl),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_c     (req0_c),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_ctl   (req1_ctl),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_c     (req1_c),
        .rsp0_valid (rsp0_valid),
        .rsp0_data  (rsp0_data),
        .rsp1_valid (rsp1_valid),
        .rsp1_data  (rsp1_data),
        .dp_reset   (dp_reset),
        .dp_ctl_1   (dp_ctl_1),
        .dp_ctl_2   (dp_ctl_2),
        .dp_a       (dp_a),
        .dp_b       (dp_b),
        .dp_c       (dp_c),
        .dp_out     (dp_out),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .busy       (busy)
`ifdef SDP_ARB_STATS_EN
        ,
        .gnt0_cnt   (gnt0_cnt),
        .gnt1_cnt   (gnt1_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath operation used both by the datapath model and the expectations.
    function automatic logic [7:0] dp_f(input logic [1:0] ctl, input logic [7:0] a,
                                        input logic [7:0] b, input logic [7:0] c);
        logic [7:0] r;
        r = ctl[1] ? (a - b) : (a + b);
        if (ctl[0]) r = r ^ c;
        return r;
    endfunction

    // Datapath model: LAT register stages; unissued slots carry garbage.
    logic [7:0] dp_pipe [LAT];
    always @(posedge clk) begin
        if (dp_reset) begin
            for (int i = 0; i < LAT; i++) dp_pipe[i] <= 8'h00;
        end else begin
            dp_pipe[0] <= (req0_ready || req1_ready) ?
                          dp_f({dp_ctl_2, dp_ctl_1}, dp_a, dp_b, dp_c) : (8'hC3 ^ cyc[7:0]);
            for (int i = 1; i < LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
        end
    end
    assign dp_out = dp_pipe[LAT-1];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard
    typedef struct {
        logic       id;
        logic [7:0] data;
        int         due;
    } exp_t;
    exp_t exp_q[$];

    task automatic push_exp(input logic id, input logic [1:0] ctl, input logic [7:0] a,
                            input logic [7:0] b, input logic [7:0] c);
        exp_q.push_back('{id: id, data: dp_f(ctl, a, b, c), due: cyc + LAT + 1});
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rsp0_valid || rsp1_valid) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rsp0_valid", rsp0_valid, !e.id);
                check("rsp1_valid", rsp1_valid, e.id);
                check("rsp_cycle", cyc, e.due);
                if (e.id) check("rsp1_data", rsp1_data, e.data);
                else      check("rsp0_data", rsp0_data, e.data);
            end
        end
    end

    task automatic idle_inputs();
        req0_valid = 0; req0_ctl = 0; req0_a = 0; req0_b = 0; req0_c = 0;
        req1_valid = 0; req1_ctl = 0; req1_a = 0; req1_b = 0; req1_c = 0;
        flush_req  = 0;
    endtask

    task automatic set_req0(input logic [1:0] ctl, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c);
        req0_valid = 1; req0_ctl = ctl; req0_a = a; req0_b = b; req0_c = c;
    endtask

    task automatic set_req1(input logic [1:0] ctl, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c);
        req1_valid = 1; req1_ctl = ctl; req1_a = a; req1_b = b; req1_c = c;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        idle_inputs();
        #1;
        check("dp_reset_in_reset", dp_reset, 1);
        @(negedge clk);
        reset = 0;
        #1;
        check("dp_reset_init", dp_reset, 1);
        check("busy_init", busy, 1);
        check("rsp0_valid_after_reset", rsp0_valid, 0);
        check("rsp1_valid_after_reset", rsp1_valid, 0);
        check("rsp0_data_after_reset", rsp0_data, 0);
        check("rsp1_data_after_reset", rsp1_data, 0);
        check("flush_done_after_reset", flush_done, 0);
        @(negedge clk);
        #1;
        check("dp_reset_run", dp_reset, 0);
        check("busy_idle", busy, 0);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a0 [3];
        logic [7:0] a1 [3];
        logic [7:0] exp_d;
        int i0, i1;

        reset = 1;
        idle_inputs();

        // Reset, then idle
        do_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            check("idle_rsp0", rsp0_valid, 0);
            check("idle_rsp1", rsp1_valid, 0);
        end

        // Single op from requester 0
        @(negedge clk);
        set_req0(2'b01, 8'h12, 8'h34, 8'h56);
        #1;
        check("single_ready0", req0_ready, 1);
        check("single_ready1", req1_ready, 0);
        check("single_dp_a", dp_a, 8'h12);
        check("single_dp_b", dp_b, 8'h34);
        check("single_dp_c", dp_c, 8'h56);
        check("single_dp_ctl_1", dp_ctl_1, 1);
        check("single_dp_ctl_2", dp_ctl_2, 0);
        check("single_busy_idle_pre", busy, 0);
        push_exp(1'b0, 2'b01, 8'h12, 8'h34, 8'h56);
        exp_d = 8'h10;  // (0x12 + 0x34) ^ 0x56
        @(negedge clk);
        idle_inputs();
        #1;
        check("single_dp_a_idle", dp_a, 0);
        check("single_busy_inflight", busy, 1);
        repeat (4) @(negedge clk);
        #1;
        check("single_rsp0_pulse_over", rsp0_valid, 0);
        check("single_rsp0_data_held", rsp0_data, exp_d);
        wait_drain();

        // Both valid for 6 cycles from the reset pointer
        do_reset();
        a0[0] = 8'h21; a0[1] = 8'h42; a0[2] = 8'h63;
        a1[0] = 8'h90; a1[1] = 8'hA5; a1[2] = 8'hF0;
        i0 = 0; i1 = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            set_req0(2'b10, a0[i0], 8'h05, 8'h00);
            set_req1(2'b11, a1[i1], 8'h11, 8'h0F);
            #1;
            check("rr_ready0", req0_ready, (k % 2) == 0);
            check("rr_ready1", req1_ready, (k % 2) == 1);
            if ((k % 2) == 0) begin
                push_exp(1'b0, 2'b10, a0[i0], 8'h05, 8'h00);
                i0++;
            end else begin
                push_exp(1'b1, 2'b11, a1[i1], 8'h11, 8'h0F);
                i1++;
            end
        end
        @(negedge clk);
        idle_inputs();
        wait_drain();

        // Flush with three operations in flight
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            set_req0(2'b00, 8'h30 + 8'(k), 8'h07, 8'h00);
            #1;
            check("flush_pre_ready0", req0_ready, 1);
            push_exp(1'b0, 2'b00, 8'h30 + 8'(k), 8'h07, 8'h00);
        end
        @(negedge clk);
        flush_req = 1;
        set_req0(2'b01, 8'h44, 8'h01, 8'h80);
        set_req1(2'b00, 8'h55, 8'h02, 8'h00);
        #1;
        check("flush_cycle_ready0", req0_ready, 0);
        check("flush_cycle_ready1", req1_ready, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            flush_req = 0;
            #1;
            check("drain_ready0", req0_ready, 0);
            check("drain_ready1", req1_ready, 0);
            check("drain_flush_done", flush_done, 0);
            check("drain_dp_reset", dp_reset, 0);
            check("drain_busy", busy, 1);
        end
        @(negedge clk);
        #1;
        check("clear_flush_done", flush_done, 1);
        check("clear_dp_reset", dp_reset, 1);
        check("clear_ready0", req0_ready, 0);
        check("clear_ready1", req1_ready, 0);
        @(negedge clk);
        #1;
        // Last grant before the flush went to requester 0, so requester 1 wins the tie.
        check("resume_ready1", req1_ready, 1);
        check("resume_ready0", req0_ready, 0);
        check("resume_flush_done", flush_done, 0);
        push_exp(1'b1, 2'b00, 8'h55, 8'h02, 8'h00);
        @(negedge clk);
        #1;
        check("resume_next_ready0", req0_ready, 1);
        push_exp(1'b0, 2'b01, 8'h44, 8'h01, 8'h80);
        @(negedge clk);
        idle_inputs();
        wait_drain();

        // Reset two cycles after a grant: that result must never appear
        @(negedge clk);
        set_req0(2'b01, 8'h77, 8'h11, 8'h22);
        #1;
        check("abort_ready0", req0_ready, 1);
        @(negedge clk);
        idle_inputs();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            check("abort_busy", busy, 0);
        end

`ifdef SDP_ARB_STATS_EN
        do_reset();
        #1;
        check("stats_gnt0_start", gnt0_cnt, 0);
        check("stats_gnt1_start", gnt1_cnt, 0);
        for (int k = 0; k < 70000; k++) begin
            @(negedge clk);
            set_req0(2'b00, 8'(k), 8'h01, 8'h00);
            #1;
            if (k == 0) check("stats_ready0", req0_ready, 1);
            push_exp(1'b0, 2'b00, 8'(k), 8'h01, 8'h00);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        check("stats_gnt0_sat", gnt0_cnt, 16'hFFFF);
        check("stats_gnt1_zero", gnt1_cnt, 0);
        check("stats_stall_zero", stall_cnt, 0);
        wait_drain();
`endif

        repeat (8) @(negedge clk);
        check("scoreboard_final_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
